// File: rtl/gpio_wiggle_pkg.sv
// gpio_wiggle_pkg: shared types and defaults for the board bring-up wiggle core
package gpio_wiggle_pkg;
    typedef enum logic [1:0] {RST, CKE_WAIT, IDLE} ddr3_state_e;
    localparam logic [3:0] DDR3_NOP = 4'b1111;
    localparam int WALK_DIV_DEF = 4;
    localparam int DDR3_RST_CYCLES_DEF = 10000;
    localparam int DDR3_CKE_CYCLES_DEF = 25000;
endpackage

// File: rtl/gpio_wiggle_core_if.sv
// gpio_wiggle_core_if: driven DDR3 control/address pins of the parked memory bus
interface gpio_wiggle_core_if;
    logic        ddr3_rstn;
    logic        ddr3_ck0;
    logic        ddr3_cke;
    logic [12:0] ddr3_a;
    logic [2:0]  ddr3_ba;
    logic [1:0]  ddr3_dm;
    logic        ddr3_csn;
    logic        ddr3_rasn;
    logic        ddr3_casn;
    logic        ddr3_wen;
    logic        ddr3_odt;
    modport master (output ddr3_rstn, ddr3_ck0, ddr3_cke, ddr3_a, ddr3_ba, ddr3_dm,
                    ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen, ddr3_odt);
    modport slave  (input  ddr3_rstn, ddr3_ck0, ddr3_cke, ddr3_a, ddr3_ba, ddr3_dm,
                    ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen, ddr3_odt);
endinterface

// File: rtl/gpio_wiggle_core_ddr3_park_seq.sv
// ddr3_park_seq: DDR3 reset/CKE power-up sequence, then NOPs forever
// DDR3_CK_TOGGLE_EN: when defined, ddr3_ck0 toggles every edge outside RST
module ddr3_park_seq
    import gpio_wiggle_pkg::*;
#(
    parameter int RST_CYCLES = DDR3_RST_CYCLES_DEF,
    parameter int CKE_CYCLES = DDR3_CKE_CYCLES_DEF
) (
    input  logic                osc,
    input  logic                perstn,
    gpio_wiggle_core_if.master  ddr
);
    localparam int CW = $clog2((RST_CYCLES > CKE_CYCLES ? RST_CYCLES : CKE_CYCLES) + 1);
    ddr3_state_e   state, next;
    logic [CW-1:0] cnt;
    logic          done;
    assign done = (state == RST && cnt == CW'(RST_CYCLES - 1)) ||
                  (state == CKE_WAIT && cnt == CW'(CKE_CYCLES - 1));
    always_ff @(posedge osc or negedge perstn)
        if (!perstn) state <= RST;
        else state <= next;
    // counter restarts on each state change and rests once IDLE
    always_ff @(posedge osc or negedge perstn)
        if (!perstn) cnt <= '0;
        else cnt <= (done || state == IDLE) ? '0 : cnt + 1'b1;
    always_comb
        next = done ? (state == RST ? CKE_WAIT : IDLE) : state;
    always_comb begin
        ddr.ddr3_rstn = state != RST;
        ddr.ddr3_cke  = state == IDLE;
        {ddr.ddr3_csn, ddr.ddr3_rasn, ddr.ddr3_casn, ddr.ddr3_wen} = DDR3_NOP;
        ddr.ddr3_a    = '0;
        ddr.ddr3_ba   = '0;
        ddr.ddr3_dm   = '0;
        ddr.ddr3_odt  = 1'b0;
    end
`ifdef DDR3_CK_TOGGLE_EN
    logic ck0;
    always_ff @(posedge osc or negedge perstn)
        if (!perstn) ck0 <= 1'b0;
        else ck0 <= (state != RST) ? ~ck0 : 1'b0;
    assign ddr.ddr3_ck0 = ck0;
`else
    assign ddr.ddr3_ck0 = 1'b0;
`endif
endmodule

// File: rtl/gpio_wiggle_core.sv
// gpio_wiggle_core: GPIO walking-one/counter patterns, SERDES idle, DDR3 parked
// DDR3_CK_TOGGLE_EN: enables ddr3_ck0 toggling inside ddr3_park_seq
module gpio_wiggle_core
    import gpio_wiggle_pkg::*;
#(
    parameter int WALK_DIV        = WALK_DIV_DEF,
    parameter int DDR3_RST_CYCLES = DDR3_RST_CYCLES_DEF,
    parameter int DDR3_CKE_CYCLES = DDR3_CKE_CYCLES_DEF
) (
    input  logic               osc,
    input  logic               perstn,
    output logic [31:0]        gpio_a,
    output logic [31:0]        gpio_b,
    input  logic               refclkp,
    input  logic               refclkn,
    input  logic               hdinp0,
    input  logic               hdinn0,
    output logic               hdoutp0,
    output logic               hdoutn0,
    inout  wire  [15:0]        ddr3_d,
    inout  wire  [1:0]         ddr3_dqs,
    gpio_wiggle_core_if.master ddr
);
    localparam int PW = WALK_DIV > 1 ? $clog2(WALK_DIV) : 1;
    logic [PW-1:0] pre;
    logic          step;
    assign step = pre == PW'(WALK_DIV - 1);
    always_ff @(posedge osc or negedge perstn)
        if (!perstn) begin
            pre    <= '0;
            gpio_a <= 32'h0000_0001;
            gpio_b <= '0;
        end else begin
            pre    <= step ? '0 : pre + 1'b1;
            gpio_a <= step ? {gpio_a[30:0], gpio_a[31]} : gpio_a;
            gpio_b <= gpio_b + 32'd1;
        end
    assign hdoutp0  = 1'b0;
    assign hdoutn0  = 1'b1;
    assign ddr3_d   = 16'bz;
    assign ddr3_dqs = 2'bz;
    wire unused_serdes = &{1'b0, refclkp, refclkn, hdinp0, hdinn0};
    ddr3_park_seq #(
        .RST_CYCLES (DDR3_RST_CYCLES),
        .CKE_CYCLES (DDR3_CKE_CYCLES)
    ) u_park (
        .osc    (osc),
        .perstn (perstn),
        .ddr    (ddr)
    );
endmodule

// File: tb/tb_gpio_wiggle_core.sv
// tb_gpio_wiggle_core: random-step checks of gpio_wiggle_core against an edge-count model
module tb_gpio_wiggle_core;
    localparam int WD = 4, RC = 20, CC = 30;
    logic        osc = 1'b0, perstn = 1'b0;
    logic [31:0] gpio_a, gpio_b;
    logic        hdoutp0, hdoutn0;
    wire  [15:0] ddr3_d;
    wire  [1:0]  ddr3_dqs;
    int          tests = 0, fails = 0;
    longint      n = 0;
    gpio_wiggle_core_if ddr();
    gpio_wiggle_core #(.WALK_DIV(WD), .DDR3_RST_CYCLES(RC), .DDR3_CKE_CYCLES(CC)) dut (
        .osc(osc), .perstn(perstn), .gpio_a(gpio_a), .gpio_b(gpio_b),
        .refclkp(1'b0), .refclkn(1'b1), .hdinp0(1'b0), .hdinn0(1'b1),
        .hdoutp0(hdoutp0), .hdoutn0(hdoutn0), .ddr3_d(ddr3_d), .ddr3_dqs(ddr3_dqs),
        .ddr(ddr)
    );
    always #10 osc = ~osc;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
        end
    endtask
    // expected outputs n rising edges after reset release
    task automatic chk_all();
        logic ck;
`ifdef DDR3_CK_TOGGLE_EN
        ck = n > RC ? 1'((n - RC) % 2) : 1'b0;
`else
        ck = 1'b0;
`endif
        chk("gpio_a", gpio_a, 64'(32'h1 << ((n / WD) % 32)));
        chk("gpio_b", gpio_b, 64'(n % (64'd1 << 32)));
        chk("ddr3_rstn", ddr.ddr3_rstn, 64'(n >= RC));
        chk("ddr3_cke", ddr.ddr3_cke, 64'(n >= RC + CC));
        chk("ddr3_ck0", ddr.ddr3_ck0, 64'(ck));
        chk("cmd", {ddr.ddr3_csn, ddr.ddr3_rasn, ddr.ddr3_casn, ddr.ddr3_wen}, 64'hF);
        chk("park", {ddr.ddr3_a, ddr.ddr3_ba, ddr.ddr3_dm, ddr.ddr3_odt}, 64'h0);
        chk("serdes", {hdoutp0, hdoutn0}, 64'b01);
    endtask
    task automatic adv(input int k);
        repeat (k) @(posedge osc);
        n += k;
        #1 chk_all();
    endtask
    task automatic release_rst();
        @(negedge osc) perstn = 1'b1;
        n = 0;
    endtask
    task automatic mid_reset();
        #4 perstn = 1'b0;
        n = 0;
        #1 chk_all();
        release_rst();
    endtask
    initial begin
        #100 chk_all();
        release_rst();
        adv(4);  adv(6);  adv(9);  adv(1);
        adv(29); adv(1);  adv(74); adv(3);  adv(1);
        adv(3);  adv(1);
        for (int i = 0; i < 25; i++) adv($urandom_range(1, 9));
        perstn = 1'b0;
        #30 release_rst();
        adv(35);
        mid_reset();
        adv(19); adv(1);
        for (int r = 0; r < 6; r++) begin
            int stop;
            stop = $urandom_range(5, 160);
            while (n < stop) adv($urandom_range(1, 7));
            mid_reset();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
